// File: rtl/imem_responder_pkg.sv
// Shared bus definitions for the tagged load/store memory protocol.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_command_t;

  localparam int MEM_TAG_W       = 4;
  localparam int MEM_LATENCY_DEF = 4;
  localparam int NUM_TAGS_DEF    = 15;
  localparam int MEM_WORDS       = 1024;
  localparam int MEM_IDX_W       = $clog2(MEM_WORDS);

endpackage

// File: rtl/imem_responder_if.sv
// Processor <-> memory command/response bundle.
interface imem_responder_if;
  import imem_responder_pkg::*;

  bus_command_t           proc2mem_command;
  logic [63:0]            proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic [MEM_TAG_W-1:0]   mem2proc_response;
  logic [MEM_TAG_W-1:0]   mem2proc_tag;
  logic [63:0]            mem2proc_data;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );
endinterface

// File: rtl/imem_responder_mem_tag_allocator.sv
// Free-tag bookkeeping: tags 1..NUM_TAGS, lowest free tag offered first.
module mem_tag_allocator
  import imem_responder_pkg::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic [MEM_TAG_W-1:0] alloc_tag,
  output logic                 any_free,
  input  logic                 free_valid,
  input  logic [MEM_TAG_W-1:0] free_tag
);

  logic [NUM_TAGS:1] free_vec;

  // Priority encoder: scanning downward leaves the lowest free tag; 0 if none.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (free_vec[i]) alloc_tag = MEM_TAG_W'(i);
    end
  end

  assign any_free = |free_vec;

  // Free-vector update; a tag being returned is never the one being allocated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_vec <= '1;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (free_valid && free_tag == MEM_TAG_W'(i))
          free_vec[i] <= 1'b1;
        else if (alloc_req && alloc_tag == MEM_TAG_W'(i))
          free_vec[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: accepts tagged loads/stores, returns load data a
// fixed MEM_LATENCY cycles after acceptance. MEM_LATENCY and NUM_TAGS: 1..15.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int NUM_TAGS    = NUM_TAGS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  imem_responder_if.slave  bus
);

  localparam logic [MEM_TAG_W-1:0] LAT_M1 = MEM_TAG_W'(MEM_LATENCY - 1);

  logic [63:0]          mem [MEM_WORDS];
  logic [MEM_TAG_W-1:0] slot_cnt  [16];
  logic [63:0]          slot_data [16];

  logic [MEM_IDX_W-1:0] idx;
  logic                 in_range;
  logic                 accept_load;
  logic                 accept_store;
  logic [63:0]          rd_word;
  logic [MEM_TAG_W-1:0] alloc_tag;
  logic                 any_free;
  logic [MEM_TAG_W-1:0] done_tag;
  logic [63:0]          done_data;
  logic [MEM_TAG_W-1:0] ret_tag;
  logic [63:0]          ret_data;
  logic                 unused_addr_lsb;

  assign idx             = bus.proc2mem_addr[3 +: MEM_IDX_W];
  assign in_range        = (bus.proc2mem_addr[63:3+MEM_IDX_W] == '0);
  assign rd_word         = mem[idx];
  assign unused_addr_lsb = ^bus.proc2mem_addr[2:0];

  // A returned tag is released one edge after its return cycle so it is
  // never reissued in the same cycle it is presented to the requester.
  mem_tag_allocator #(.NUM_TAGS(NUM_TAGS)) u_alloc (
    .clock      (clock),
    .reset      (reset),
    .alloc_req  (accept_load),
    .alloc_tag  (alloc_tag),
    .any_free   (any_free),
    .free_valid (ret_tag != '0),
    .free_tag   (ret_tag)
  );

  // Command decode and combinational acceptance tag; 2'b11 falls out as none.
  always_comb begin
    accept_load  = reset && (bus.proc2mem_command == BUS_LOAD) && in_range && any_free;
    accept_store = reset && (bus.proc2mem_command == BUS_STORE) && in_range;
    if (accept_load)
      bus.mem2proc_response = alloc_tag;
    else if (accept_store)
      bus.mem2proc_response = any_free ? alloc_tag : MEM_TAG_W'(1);
    else
      bus.mem2proc_response = '0;
  end

  // Pick the completing load: a slot at count 1, or the load accepted this
  // cycle when the latency is a single cycle.
  always_comb begin
    done_tag  = '0;
    done_data = '0;
    if (MEM_LATENCY == 1) begin
      if (accept_load) begin
        done_tag  = alloc_tag;
        done_data = rd_word;
      end
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (slot_cnt[i] == MEM_TAG_W'(1)) begin
          done_tag  = MEM_TAG_W'(i);
          done_data = slot_data[i];
        end
      end
    end
  end

  // Per-tag countdowns and the registered return port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '{default: '0};
      ret_tag  <= '0;
      ret_data <= '0;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) begin
        if (slot_cnt[i] != '0) slot_cnt[i] <= slot_cnt[i] - MEM_TAG_W'(1);
      end
      if (accept_load && MEM_LATENCY > 1) slot_cnt[alloc_tag] <= LAT_M1;
      ret_tag  <= done_tag;
      ret_data <= done_data;
    end
  end

  // Load snapshot captured at acceptance; no reset needed, guarded by the count.
  always_ff @(posedge clock) begin
    if (accept_load) slot_data[alloc_tag] <= rd_word;
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (accept_store) mem[idx] <= bus.proc2mem_data;
  end

  assign bus.mem2proc_tag  = ret_tag;
  assign bus.mem2proc_data = ret_data;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: the driver checks acceptance tags and queues expected
// returns; per-DUT monitors pop and compare whenever a return tag appears.
module tb_imem_responder;
  import imem_responder_pkg::*;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  imem_responder_if b0 ();
  imem_responder_if b1 ();

  imem_responder #(.MEM_LATENCY(4), .NUM_TAGS(15)) u_dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b0.slave)
  );

  imem_responder #(.MEM_LATENCY(4), .NUM_TAGS(2)) u_dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (b1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (b0.mem2proc_tag != 4'd0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected return: got tag %0d expected none (cycle %0d)", b0.mem2proc_tag, cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0 return tag", 64'(b0.mem2proc_tag), 64'(e.tag));
        chk("dut0 return data", b0.mem2proc_data, e.data);
        chk("dut0 return cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("dut0 idle data", b0.mem2proc_data, 64'd0);
    end
    if (b1.mem2proc_tag != 4'd0) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected return: got tag %0d expected none (cycle %0d)", b1.mem2proc_tag, cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1 return tag", 64'(b1.mem2proc_tag), 64'(e.tag));
        chk("dut1 return data", b1.mem2proc_data, e.data);
        chk("dut1 return cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("dut1 idle data", b1.mem2proc_data, 64'd0);
    end
  end

  task automatic set_bus(input int d, input bus_command_t cmd, input logic [63:0] addr, input logic [63:0] wdata);
    b0.proc2mem_command = (d == 0) ? cmd : BUS_NONE;
    b0.proc2mem_addr    = (d == 0) ? addr : 64'd0;
    b0.proc2mem_data    = (d == 0) ? wdata : 64'd0;
    b1.proc2mem_command = (d == 1) ? cmd : BUS_NONE;
    b1.proc2mem_addr    = (d == 1) ? addr : 64'd0;
    b1.proc2mem_data    = (d == 1) ? wdata : 64'd0;
  endtask

  // One command in one cycle; checks the acceptance tag and queues the return.
  task automatic issue(input int d, input bus_command_t cmd, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [3:0] exp_resp,
                       input logic [63:0] exp_data, input string name);
    exp_t e;
    @(negedge clk);
    set_bus(d, cmd, addr, wdata);
    #1;
    chk(name, 64'((d == 0) ? b0.mem2proc_response : b1.mem2proc_response), 64'(exp_resp));
    if (cmd == BUS_LOAD && exp_resp != 4'd0) begin
      e.due  = cyc + 4;
      e.tag  = exp_resp;
      e.data = exp_data;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_bus(0, BUS_NONE, 64'd0, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_command_t bad_cmd;
    bad_cmd = bus_command_t'(2'b11);
    set_bus(0, BUS_LOAD, 64'h40, 64'd0);
    #2;
    chk("reset response", 64'(b0.mem2proc_response), 64'd0);
    chk("reset tag", 64'(b0.mem2proc_tag), 64'd0);
    chk("reset data", b0.mem2proc_data, 64'd0);
    @(negedge clk);
    set_bus(0, BUS_NONE, 64'd0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Store then load the same word next cycle
    issue(0, BUS_STORE, 64'h40, 64'h1234, 4'd1, 64'd0, "t1 store resp");
    issue(0, BUS_LOAD,  64'h40, 64'd0,    4'd1, 64'h1234, "t1 load resp");
    idle(6);

    // Back-to-back loads
    issue(0, BUS_STORE, 64'h00, 64'hA0, 4'd1, 64'd0, "t2 store0 resp");
    issue(0, BUS_STORE, 64'h08, 64'hA8, 4'd1, 64'd0, "t2 store1 resp");
    issue(0, BUS_STORE, 64'h10, 64'hB0, 4'd1, 64'd0, "t2 store2 resp");
    issue(0, BUS_LOAD,  64'h00, 64'd0, 4'd1, 64'hA0, "t2 load0 resp");
    issue(0, BUS_LOAD,  64'h08, 64'd0, 4'd2, 64'hA8, "t2 load1 resp");
    issue(0, BUS_LOAD,  64'h10, 64'd0, 4'd3, 64'hB0, "t2 load2 resp");
    idle(6);

    // Load snapshots memory before a following store
    issue(0, BUS_STORE, 64'h40, 64'hAA, 4'd1, 64'd0, "t4 store old resp");
    issue(0, BUS_LOAD,  64'h40, 64'd0, 4'd1, 64'hAA, "t4 load old resp");
    issue(0, BUS_STORE, 64'h40, 64'hBB, 4'd2, 64'd0, "t4 store new resp");
    idle(6);
    issue(0, BUS_LOAD,  64'h40, 64'd0, 4'd1, 64'hBB, "t4 load new resp");
    idle(6);

    // Range limits and non-commands
    issue(0, BUS_LOAD,  64'h2000, 64'd0, 4'd0, 64'd0, "t5 load oor resp");
    issue(0, BUS_LOAD,  64'h8000_0000_0000_0040, 64'd0, 4'd0, 64'd0, "t5 load high resp");
    issue(0, BUS_STORE, 64'h2000, 64'hDEAD, 4'd0, 64'd0, "t5 store oor resp");
    issue(0, BUS_NONE,  64'h40, 64'd0, 4'd0, 64'd0, "t5 none resp");
    issue(0, bad_cmd,   64'h40, 64'd0, 4'd0, 64'd0, "t5 illegal resp");
    issue(0, BUS_STORE, 64'h1FFF, 64'h5A, 4'd1, 64'd0, "t5 store last resp");
    issue(0, BUS_LOAD,  64'h1FF8, 64'd0, 4'd1, 64'h5A, "t5 load last resp");
    idle(20);
    issue(0, BUS_LOAD,  64'h00, 64'd0, 4'd1, 64'hA0, "t5 word0 intact resp");
    idle(6);

    // Reset mid-countdown drops outstanding loads
    issue(0, BUS_LOAD, 64'h00, 64'd0, 4'd1, 64'hA0, "t6 load0 resp");
    issue(0, BUS_LOAD, 64'h08, 64'd0, 4'd2, 64'hA8, "t6 load1 resp");
    @(negedge clk);
    rst_n = 1'b0;
    set_bus(0, BUS_LOAD, 64'h10, 64'd0);
    q0.delete();
    #1;
    chk("t6 resp in reset", 64'(b0.mem2proc_response), 64'd0);
    chk("t6 tag in reset", 64'(b0.mem2proc_tag), 64'd0);
    chk("t6 data in reset", b0.mem2proc_data, 64'd0);
    @(negedge clk);
    chk("t6 resp late reset", 64'(b0.mem2proc_response), 64'd0);
    rst_n = 1'b1;
    set_bus(0, BUS_NONE, 64'd0, 64'd0);
    idle(10);
    issue(0, BUS_LOAD, 64'h08, 64'd0, 4'd1, 64'hA8, "t6 load after reset resp");
    idle(6);

    // Two-tag responder: exhaustion, store without free tag, reissue timing
    issue(1, BUS_STORE, 64'h00, 64'h11, 4'd1, 64'd0, "t3 store0 resp");
    issue(1, BUS_STORE, 64'h08, 64'h22, 4'd1, 64'd0, "t3 store1 resp");
    issue(1, BUS_STORE, 64'h10, 64'h33, 4'd1, 64'd0, "t3 store2 resp");
    issue(1, BUS_STORE, 64'h18, 64'h44, 4'd1, 64'd0, "t3 store3 resp");
    issue(1, BUS_LOAD,  64'h00, 64'd0, 4'd1, 64'h11, "t3 load a resp");
    issue(1, BUS_LOAD,  64'h08, 64'd0, 4'd2, 64'h22, "t3 load b resp");
    issue(1, BUS_LOAD,  64'h10, 64'd0, 4'd0, 64'd0,  "t3 load c full resp");
    issue(1, BUS_STORE, 64'h20, 64'h55, 4'd1, 64'd0, "t3 store full resp");
    issue(1, BUS_LOAD,  64'h10, 64'd0, 4'd0, 64'd0,  "t3 retry in return cycle resp");
    issue(1, BUS_LOAD,  64'h10, 64'd0, 4'd1, 64'h33, "t3 retry after free resp");
    issue(1, BUS_LOAD,  64'h20, 64'd0, 4'd2, 64'h55, "t3 load d resp");
    idle(10);

    chk("dut0 queue drained", 64'(q0.size()), 64'd0);
    chk("dut1 queue drained", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
